// File: rtl/sr_latch_driver_pkg.sv
// rtl/sr_latch_driver_pkg.sv - state encoding and shared constants for the SR latch driver
package sr_latch_driver_pkg;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_SETUP = 3'd1,
        ST_PULSE = 3'd2,
        ST_HOLD  = 3'd3,
        ST_CHECK = 3'd4,
        ST_GAP   = 3'd5
    } drv_state_t;

    // Number of cycles spent in CHECK when readback is compiled in.
    localparam int CHECK_LEN = 3;

endpackage

// File: rtl/sr_pulse_timer.sv
// rtl/sr_pulse_timer.sv - loadable down-counter with zero flag, saturating at 0
module sr_pulse_timer #(
    parameter int CNT_W = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             load,
    input  logic [CNT_W-1:0] load_val,
    output logic             cnt_zero
);

    logic [CNT_W-1:0] count;

    // Load takes priority; otherwise count down and stick at zero (no wrap).
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count <= '0;
        end else if (load) begin
            count <= load_val;
        end else if (count != '0) begin
            count <= count - 1'b1;
        end
    end

    assign cnt_zero = (count == '0);

endmodule

// File: rtl/sr_latch_driver.sv
// rtl/sr_latch_driver.sv - set/reset command to timed S/R/Enable pulse driver (option: SR_READBACK_CHECK_EN)
module sr_latch_driver
    import sr_latch_driver_pkg::*;
#(
    parameter int PULSE_W = 2,
    parameter int GAP_W   = 10,
    parameter int CNT_W   = 8
) (
    input  logic clk,
    input  logic rst_n,
    input  logic cmd_valid,
    input  logic cmd_set,
    output logic cmd_ready,
    output logic S,
    output logic R,
    output logic Enable,
    output logic busy,
    input  logic Qa,
    input  logic Qb,
    output logic err
);

    // A zero pulse width still produces one Enable cycle.
    localparam int               PULSE_EFF  = (PULSE_W == 0) ? 1 : PULSE_W;
    localparam logic [CNT_W-1:0] PULSE_LOAD = CNT_W'(PULSE_EFF - 1);
    localparam logic [CNT_W-1:0] GAP_LOAD   = CNT_W'((GAP_W == 0) ? 0 : GAP_W - 1);
    localparam drv_state_t       POST_WRITE = (GAP_W == 0) ? ST_IDLE : ST_GAP;

    drv_state_t       state;
    drv_state_t       next_state;
    logic             set_q;
    logic             set_next;
    logic             accept;
    logic             tmr_load;
    logic [CNT_W-1:0] tmr_val;
    logic             tmr_zero;

    sr_pulse_timer #(.CNT_W(CNT_W)) u_timer (
        .clk      (clk),
        .rst_n    (rst_n),
        .load     (tmr_load),
        .load_val (tmr_val),
        .cnt_zero (tmr_zero)
    );

`ifdef SR_READBACK_CHECK_EN
    localparam logic [CNT_W-1:0] CHECK_LOAD = CNT_W'(CHECK_LEN - 1);

    logic [1:0] qa_sync;
    logic [1:0] qb_sync;

    // Two-flop synchronisers: the latch outputs are asynchronous to clk.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            qa_sync <= 2'b00;
            qb_sync <= 2'b00;
        end else begin
            qa_sync <= {qa_sync[0], Qa};
            qb_sync <= {qb_sync[0], Qb};
        end
    end

    // Sticky readback error, judged on the final CHECK cycle.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            err <= 1'b0;
        end else if (state == ST_CHECK && tmr_zero &&
                     (qa_sync[1] != set_q || qb_sync[1] != ~set_q)) begin
            err <= 1'b1;
        end
    end
`else
    logic unused_readback;
    assign unused_readback = Qa ^ Qb;
    assign err             = 1'b0;
`endif

    // Next-state and timer-load decode; the timer is loaded on entry to timed states.
    always_comb begin
        next_state = state;
        accept     = 1'b0;
        tmr_load   = 1'b0;
        tmr_val    = '0;
        case (state)
            ST_IDLE: begin
                if (cmd_valid && cmd_ready) begin
                    accept     = 1'b1;
                    next_state = ST_SETUP;
                end
            end
            ST_SETUP: begin
                next_state = ST_PULSE;
                tmr_load   = 1'b1;
                tmr_val    = PULSE_LOAD;
            end
            ST_PULSE: begin
                if (tmr_zero) next_state = ST_HOLD;
            end
            ST_HOLD: begin
`ifdef SR_READBACK_CHECK_EN
                next_state = ST_CHECK;
                tmr_load   = 1'b1;
                tmr_val    = CHECK_LOAD;
`else
                next_state = POST_WRITE;
                tmr_load   = (POST_WRITE == ST_GAP);
                tmr_val    = GAP_LOAD;
`endif
            end
            ST_CHECK: begin
                if (tmr_zero) begin
                    next_state = POST_WRITE;
                    tmr_load   = (POST_WRITE == ST_GAP);
                    tmr_val    = GAP_LOAD;
                end
            end
            ST_GAP: begin
                if (tmr_zero) next_state = ST_IDLE;
            end
            default: next_state = ST_IDLE;
        endcase
        set_next = accept ? cmd_set : set_q;
    end

    // State and registered outputs, all decoded from the state being entered.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= ST_IDLE;
            set_q     <= 1'b0;
            S         <= 1'b0;
            R         <= 1'b0;
            Enable    <= 1'b0;
            cmd_ready <= 1'b1;
            busy      <= 1'b0;
        end else begin
            state     <= next_state;
            set_q     <= set_next;
            S         <= set_next  && (next_state inside {ST_SETUP, ST_PULSE, ST_HOLD});
            R         <= !set_next && (next_state inside {ST_SETUP, ST_PULSE, ST_HOLD});
            Enable    <= (next_state == ST_PULSE);
            cmd_ready <= (next_state == ST_IDLE);
            busy      <= (next_state != ST_IDLE);
        end
    end

endmodule
